// File: rtl/core_result_collector_if.sv
// Bundle of the core-side capture inputs and the result drain interface of core_result_collector.
// The master modport is the environment; the slave modport is the collector.
interface core_result_collector_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic [WIDTH-1:0] core_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [WIDTH-1:0] checksum;

    modport master (
        output in_valid, core_data, out_ready,
        input  out_valid, out_data, count, overflow, checksum
    );

    modport slave (
        input  in_valid, core_data, out_ready,
        output out_valid, out_data, count, overflow, checksum
    );
endinterface

// File: rtl/core_result_collector.sv
// Re-times the upstream valid across the core latency and collects core results into a FWFT FIFO.
// Optional running checksum of pushed words when CORE_COLLECTOR_CHECKSUM_EN is defined.
module core_result_collector #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 16,
    parameter int DEPTH   = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    core_result_collector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [LATENCY-1:0] vsr_q, vsr_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;

    logic cap_s;
    logic full_s;
    logic pop_s;
    logic push_s;

    // Valid delay line matched to the core latency
    always_comb begin
        vsr_d    = {LATENCY{1'b0}};
        vsr_d[0] = bus.in_valid;
        for (int k = 1; k < LATENCY; k++) begin
            vsr_d[k] = vsr_q[k-1];
        end
    end

    // Capture / push / pop decisions; a full FIFO still accepts a capture when the head leaves
    always_comb begin
        cap_s  = vsr_q[LATENCY-1];
        full_s = (count_q == FULL_COUNT);
        pop_s  = out_valid_q & bus.out_ready;
        push_s = cap_s & (~full_s | pop_s);
    end

    // FIFO next state; the head word and valid are registered from the post-edge state
    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = bus.core_data;
            wr_ptr_d        = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
        overflow_d  = overflow_q | (cap_s & full_s & ~pop_s);
        out_valid_d = (count_d != {CW{1'b0}});
        out_data_d  = mem_d[rd_ptr_d];
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsr_q       <= {LATENCY{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
        end else begin
            vsr_q       <= vsr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef CORE_COLLECTOR_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_q, checksum_d;

    function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], x[WIDTH-1]};
    endfunction

    // Running checksum folds in pushed words only; dropped captures leave it untouched
    always_comb begin
        if (push_s) begin
            checksum_d = rotl1(checksum_q) ^ bus.core_data;
        end else begin
            checksum_d = checksum_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum_q <= {WIDTH{1'b0}};
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign bus.checksum = checksum_q;
`else
    assign bus.checksum = {WIDTH{1'b0}};
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_core_result_collector.sv
// Self-checking bench for core_result_collector (LATENCY=16, DEPTH=8): directed table, corner sequences
// and a randomized run, all checked every cycle against a queue-based reference model.
module tb_core_result_collector;
    localparam int W     = 32;
    localparam int LAT   = 16;
    localparam int DEPTH = 8;

    logic clk;
    logic rst_n;

    core_result_collector_if #(.WIDTH(W), .DEPTH(DEPTH)) bus ();

    core_result_collector #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: due edges of pending captures, FIFO contents as a queue
    int          e = 0;
    int          due[$];
    logic [31:0] fifo[$];
    bit          m_ovf = 1'b0;
    logic [31:0] m_cs  = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic model_edge();
        bit cap;
        bit pop;
        int sz;
        if (!rst_n) begin
            due.delete();
            fifo.delete();
            m_ovf = 1'b0;
            m_cs  = 32'h0;
        end else begin
            cap = (due.size() > 0) && (due[0] == e);
            if (cap) void'(due.pop_front());
            sz  = fifo.size();
            pop = (sz > 0) && bus.out_ready;
            if (pop) void'(fifo.pop_front());
            if (cap) begin
                if (sz < DEPTH || pop) begin
                    fifo.push_back(bus.core_data);
`ifdef CORE_COLLECTOR_CHECKSUM_EN
                    m_cs = {m_cs[30:0], m_cs[31]} ^ bus.core_data;
`endif
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (bus.in_valid) due.push_back(e + LAT);
        end
        e++;
    endtask

    task automatic check_all();
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, fifo.size() > 0});
        chk("count", {60'd0, bus.count}, 64'(fifo.size()));
        chk("overflow", {63'd0, bus.overflow}, {63'd0, m_ovf});
        chk("checksum", {32'd0, bus.checksum}, {32'd0, m_cs});
        if (fifo.size() > 0) chk("out_data", {32'd0, bus.out_data}, {32'd0, fifo[0]});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          n;
        logic [31:0] base;
        int          exp_count;
        bit          exp_ovf;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{n: 1,  base: 32'h0000_0000, exp_count: 1, exp_ovf: 1'b0};
        tbl[1] = '{n: 10, base: 32'h0000_0000, exp_count: 8, exp_ovf: 1'b1};
        tbl[2] = '{n: 8,  base: 32'hA5A5_0000, exp_count: 8, exp_ovf: 1'b0};
        tbl[3] = '{n: 9,  base: 32'hC0DE_0100, exp_count: 8, exp_ovf: 1'b1};
        tbl[4] = '{n: 3,  base: 32'h7FFF_FFFE, exp_count: 3, exp_ovf: 1'b0};

        // Reset held two edges with in_valid high
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        bus.core_data = 32'h0;
        step();
        step();
        chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_count", {60'd0, bus.count}, 64'd0);
        chk("rst_ovf", {63'd0, bus.overflow}, 64'd0);
        chk("rst_cs", {32'd0, bus.checksum}, 64'd0);
        rst_n = 1'b1;

        // Single valid: result appears exactly after edge LAT
        for (int j = 0; j <= LAT; j++) begin
            bus.in_valid  = (j == 0);
            bus.core_data = (j == LAT) ? 32'h1234_5678 : $urandom;
            step();
            if (j < LAT) chk("lat_early", {63'd0, bus.out_valid}, 64'd0);
        end
        chk("lat_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("lat_data", {32'd0, bus.out_data}, 64'h1234_5678);
        chk("lat_count", {60'd0, bus.count}, 64'd1);

        // Table: n back-to-back valids with consumer stalled, then drain
        for (int i = 0; i < 5; i++) begin
            do_reset();
            for (int j = 0; j < tbl[i].n + LAT; j++) begin
                bus.in_valid  = (j < tbl[i].n);
                bus.core_data = tbl[i].base + 32'(j - LAT);
                step();
            end
            bus.in_valid = 1'b0;
            chk("tbl_count", {60'd0, bus.count}, 64'(tbl[i].exp_count));
            chk("tbl_ovf", {63'd0, bus.overflow}, {63'd0, tbl[i].exp_ovf});
            for (int k = 0; k < tbl[i].exp_count; k++) begin
                chk("tbl_data", {32'd0, bus.out_data}, {32'd0, tbl[i].base + 32'(k)});
                bus.out_ready = 1'b1;
                step();
            end
            bus.out_ready = 1'b0;
            chk("tbl_empty", {63'd0, bus.out_valid}, 64'd0);
        end

        // Full FIFO with simultaneous capture and pop
        do_reset();
        for (int j = 0; j <= 8 + LAT; j++) begin
            bus.in_valid  = (j <= 8);
            bus.out_ready = (j == 8 + LAT);
            bus.core_data = 32'hBEEF_0000 + 32'(j - LAT);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("full_count", {60'd0, bus.count}, 64'd8);
        chk("full_ovf", {63'd0, bus.overflow}, 64'd0);
        chk("full_head", {32'd0, bus.out_data}, 64'hBEEF_0001);

        // Checksum sequence
        do_reset();
        for (int j = 0; j <= LAT + 1; j++) begin
            bus.in_valid  = (j < 2);
            bus.core_data = (j == LAT) ? 32'h0000_0001 : (j == LAT + 1) ? 32'h8000_0000 : $urandom;
            step();
`ifdef CORE_COLLECTOR_CHECKSUM_EN
            if (j == LAT)     chk("cs_first", {32'd0, bus.checksum}, 64'h0000_0001);
            if (j == LAT + 1) chk("cs_second", {32'd0, bus.checksum}, 64'h8000_0002);
`else
            if (j == LAT + 1) chk("cs_tied", {32'd0, bus.checksum}, 64'd0);
`endif
        end
        bus.in_valid = 1'b0;

        // Mid-flight reset discards pending valids
        do_reset();
        for (int j = 0; j <= 30; j++) begin
            bus.in_valid  = (j <= 3);
            rst_n         = (j != 5);
            bus.core_data = $urandom;
            step();
            chk("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
            chk("midrst_count", {60'd0, bus.count}, 64'd0);
        end
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        for (int j = 0; j < 3000; j++) begin
            rst_n         = ($urandom_range(0, 299) != 0);
            bus.in_valid  = ($urandom_range(0, 99) < 60);
            bus.out_ready = (j < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            bus.core_data = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
